// File: rtl/alu_writeback.sv
// ALU result writeback: buffers 128-bit ALU results in a small FIFO and drains them
// into the 64-bit GPR file one word per cycle, with optional high-word and flags writes.
module alu_writeback #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         exe_mem,
    input  logic [127:0] result,
    input  logic [63:0]  flags,
    input  logic [3:0]   dest_lo,
    input  logic [3:0]   dest_hi,
    input  logic         wr_hi,
    input  logic         wr_flags,
    output logic         in_ready,
    output logic         rf_wr_en,
    output logic [3:0]   rf_wr_reg,
    output logic [63:0]  rf_wr_data,
    input  logic         rf_wr_ready,
    output logic         flags_wr_en,
    output logic [63:0]  flags_wr_data,
    output logic         retire,
    output logic         busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [127:0] result;
        logic [63:0]  flags;
        logic [3:0]   dest_lo;
        logic [3:0]   dest_hi;
        logic         wr_hi;
        logic         wr_flags;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;

    logic push;
    logic pop;
    logic more;

    assign head     = mem[rd_ptr];
    assign in_ready = !reset && (count < FULL);
    assign push     = exe_mem && in_ready;
    assign pop      = retire;
    // Another entry will be at the head after this pop: one already queued or one arriving now.
    assign more     = (count > CW'(1)) || push;
    assign busy     = !reset && ((count != '0) || (state != IDLE));

    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
    always_comb begin
        rf_wr_en      = 1'b0;
        rf_wr_reg     = '0;
        rf_wr_data    = '0;
        flags_wr_en   = 1'b0;
        flags_wr_data = '0;
        retire        = 1'b0;
        if (!reset) begin
            case (state)
                LO: begin
                    rf_wr_en    = 1'b1;
                    rf_wr_reg   = head.dest_lo;
                    rf_wr_data  = head.result[63:0];
                    flags_wr_en = rf_wr_ready && head.wr_flags;
                    if (flags_wr_en) flags_wr_data = head.flags;
                    retire      = rf_wr_ready && !head.wr_hi;
                end
                HI: begin
                    rf_wr_en   = 1'b1;
                    rf_wr_reg  = head.dest_hi;
                    rf_wr_data = head.result[127:64];
                    retire     = rf_wr_ready;
                end
                default: ;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{result, flags, dest_lo, dest_hi, wr_hi, wr_flags};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            case (state)
                IDLE: if ((count != '0) || push) state <= LO;
                LO: if (rf_wr_ready) begin
                    if (head.wr_hi) state <= HI;
                    else            state <= more ? LO : IDLE;
                end
                HI: if (rf_wr_ready) state <= more ? LO : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (DEPTH=4): single writes, dual-word
// writes, back-pressure, full-buffer refusal, streaming and reset during a stalled write.
module tb_alu_writeback;

    logic         clk;
    logic         reset;
    logic         exe_mem;
    logic [127:0] result;
    logic [63:0]  flags;
    logic [3:0]   dest_lo;
    logic [3:0]   dest_hi;
    logic         wr_hi;
    logic         wr_flags;
    logic         in_ready;
    logic         rf_wr_en;
    logic [3:0]   rf_wr_reg;
    logic [63:0]  rf_wr_data;
    logic         rf_wr_ready;
    logic         flags_wr_en;
    logic [63:0]  flags_wr_data;
    logic         retire;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    alu_writeback #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .exe_mem      (exe_mem),
        .result       (result),
        .flags        (flags),
        .dest_lo      (dest_lo),
        .dest_hi      (dest_hi),
        .wr_hi        (wr_hi),
        .wr_flags     (wr_flags),
        .in_ready     (in_ready),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_reg    (rf_wr_reg),
        .rf_wr_data   (rf_wr_data),
        .rf_wr_ready  (rf_wr_ready),
        .flags_wr_en  (flags_wr_en),
        .flags_wr_data(flags_wr_data),
        .retire       (retire),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later, mid low phase.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic drive(input logic ex, input logic [127:0] res, input logic [63:0] fl,
                         input logic [3:0] dlo, input logic [3:0] dhi,
                         input logic whi, input logic wfl, input logic rdy);
        exe_mem     = ex;
        result      = res;
        flags       = fl;
        dest_lo     = dlo;
        dest_hi     = dhi;
        wr_hi       = whi;
        wr_flags    = wfl;
        rf_wr_ready = rdy;
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [3:0] rg,
                            input logic [63:0] data, input logic ret);
        check({tag, ".en"},     rf_wr_en,   en);
        check({tag, ".reg"},    rf_wr_reg,  rg);
        check({tag, ".data"},   rf_wr_data, data);
        check({tag, ".retire"}, retire,     ret);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Reset state
        next_cycle(); #1;
        next_cycle(); #1;
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.flags_en", flags_wr_en, 1'b0);
        check("rst.flags_data", flags_wr_data, 64'h0);
        check_wr("rst", 1'b0, 4'd0, 64'h0, 1'b0);
        next_cycle(); reset = 1'b0; #1;
        check("post_rst.in_ready", in_ready, 1'b1);
        check("post_rst.busy", busy, 1'b0);

        // Single low-word write with flags
        next_cycle(); drive(1'b1, 128'h2A, 64'h44, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
        check("t1.n.rf_en", rf_wr_en, 1'b0);
        next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_wr("t1.n1", 1'b1, 4'd3, 64'h2A, 1'b1);
        check("t1.n1.flags_en", flags_wr_en, 1'b1);
        check("t1.n1.flags_data", flags_wr_data, 64'h44);
        check("t1.n1.busy", busy, 1'b1);
        next_cycle(); #1;
        check_wr("t1.n2", 1'b0, 4'd0, 64'h0, 1'b0);
        check("t1.n2.busy", busy, 1'b0);
        check("t1.n2.flags_en", flags_wr_en, 1'b0);

        // Dual-word write, no flags
        next_cycle(); drive(1'b1, {64'h1111, 64'h2222}, 64'h99, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1);
        next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_wr("t2.lo", 1'b1, 4'd0, 64'h2222, 1'b0);
        check("t2.lo.flags_en", flags_wr_en, 1'b0);
        next_cycle(); #1;
        check_wr("t2.hi", 1'b1, 4'd2, 64'h1111, 1'b1);
        check("t2.hi.flags_en", flags_wr_en, 1'b0);
        next_cycle(); #1;
        check("t2.idle.busy", busy, 1'b0);

        // Back-pressure: five pushes while the register file stalls, fifth is dropped
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive(1'b1, 128'(i + 1), '0, 4'(i + 4), 4'd0, 1'b0, 1'b0, 1'b0);
            check($sformatf("t3.push%0d.in_ready", i), in_ready, (i < 4) ? 1'b1 : 1'b0);
            if (i > 0) check_wr($sformatf("t3.stall%0d", i), 1'b1, 4'd4, 64'h1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
            check_wr($sformatf("t3.drain%0d", i), 1'b1, 4'(i + 4), 64'(i + 1), 1'b1);
        end
        next_cycle(); #1;
        check("t3.done.rf_en", rf_wr_en, 1'b0);
        check("t3.done.busy", busy, 1'b0);

        // Full buffer: push refused in the pop cycle, accepted the cycle after
        for (int i = 0; i < 4; i++) begin
            next_cycle(); drive(1'b1, 128'(8'h30 + i), '0, 4'(i + 1), 4'd0, 1'b0, 1'b0, 1'b0);
        end
        next_cycle(); drive(1'b1, 128'hBAD, '0, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);
        check("t4.full_pop.in_ready", in_ready, 1'b0);
        check_wr("t4.full_pop", 1'b1, 4'd1, 64'h30, 1'b1);
        next_cycle(); drive(1'b1, 128'h34, '0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
        check("t4.refill.in_ready", in_ready, 1'b1);
        check_wr("t4.refill", 1'b1, 4'd2, 64'h31, 1'b0);
        next_cycle(); drive(1'b1, 128'hBAD2, '0, 4'd14, 4'd0, 1'b0, 1'b0, 1'b0);
        check("t4.full_again.in_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
            check_wr($sformatf("t4.drain%0d", i), 1'b1, 4'(i + 2), 64'(8'h31 + i), 1'b1);
        end
        next_cycle(); #1;
        check("t4.done.rf_en", rf_wr_en, 1'b0);

        // Streaming: push and pop every cycle, one write per cycle in push order
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(1'b1, 128'(12'h100 + i), '0, 4'(i + 8), 4'd0, 1'b0, 1'b0, 1'b1);
            if (i > 0) begin
                check_wr($sformatf("t5.s%0d", i), 1'b1, 4'(i + 7), 64'(12'h100 + i - 1), 1'b1);
                check($sformatf("t5.s%0d.in_ready", i), in_ready, 1'b1);
            end
        end
        next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_wr("t5.last", 1'b1, 4'd13, 64'h105, 1'b1);
        next_cycle(); #1;
        check("t5.done.busy", busy, 1'b0);

        // Same register for both words: low then high, high last
        next_cycle(); drive(1'b1, {64'hAAAA, 64'h5555}, '0, 4'd7, 4'd7, 1'b1, 1'b0, 1'b1);
        next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_wr("t6.lo", 1'b1, 4'd7, 64'h5555, 1'b0);
        next_cycle(); #1;
        check_wr("t6.hi", 1'b1, 4'd7, 64'hAAAA, 1'b1);

        // Reset while stalled in the high-word write
        next_cycle(); drive(1'b1, {64'hDEAD, 64'hBEEF}, 64'h7, 4'd1, 4'd9, 1'b1, 1'b1, 1'b0);
        next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_wr("t7.lo_stall", 1'b1, 4'd1, 64'hBEEF, 1'b0);
        next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("t7.lo.flags_en", flags_wr_en, 1'b1);
        check("t7.lo.flags_data", flags_wr_data, 64'h7);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            check_wr($sformatf("t7.hi_stall%0d", i), 1'b1, 4'd9, 64'hDEAD, 1'b0);
        end
        next_cycle(); reset = 1'b1; drive(1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("t7.rst.retire", retire, 1'b0);
        check("t7.rst.in_ready", in_ready, 1'b0);
        next_cycle(); reset = 1'b0; #1;
        check_wr("t7.after", 1'b0, 4'd0, 64'h0, 1'b0);
        check("t7.after.busy", busy, 1'b0);
        check("t7.after.in_ready", in_ready, 1'b1);
        next_cycle(); #1;
        check_wr("t7.after2", 1'b0, 4'd0, 64'h0, 1'b0);
        check("t7.after2.flags_en", flags_wr_en, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DEPTH, default 4, result-buffer entries; power of two, >= 2.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 exe_mem  input  1  ALU result valid for this cycle.
REQ-005 result  input  128  ALU result; [63:0] low word, [127:64] high word.
REQ-006 flags  input  64  ALU flags value for this result.
REQ-007 dest_lo  input  4  GPR index receiving result[63:0].
REQ-008 dest_hi  input  4  GPR index receiving result[127:64].
REQ-009 wr_hi  input  1  high word also written (e.g. RDX of MUL/DIV).
REQ-010 wr_flags  input  1  flags written with this result.
REQ-011 in_ready  output  1  buffer can accept; push = exe_mem && in_ready.
REQ-012 rf_wr_en  output  1  register-file write request.
REQ-013 rf_wr_reg  output  4  register-file write index.
REQ-014 rf_wr_data  output  64  register-file write data.
REQ-015 rf_wr_ready  input  1  register file accepts; write completes when rf_wr_en && rf_wr_ready.
REQ-016 flags_wr_en  output  1  flags-register write strobe, single cycle.
REQ-017 flags_wr_data  output  64  flags value written.
REQ-018 retire  output  1  one-cycle pulse; head entry fully written.
REQ-019 busy  output  1  high when buffer non-empty or state != IDLE.

Function
REQ-020 Buffer SHALL be a DEPTH-entry circular FIFO of {result, flags, dest_lo, dest_hi, wr_hi, wr_flags}; read/write pointers wrap DEPTH-1 -> 0; count width log2(DEPTH)+1.
REQ-021 in_ready SHALL be high iff count < DEPTH and reset low; at count == DEPTH a push is refused even if a pop occurs the same cycle.
REQ-022 exe_mem while in_ready low SHALL be dropped, no state change; upstream holds ALU stage.
REQ-023 Drain FSM SHALL have states IDLE, LO, HI.
REQ-024 IDLE -> LO at the edge where count != 0 or push occurs; else stay IDLE.
REQ-025 In LO: rf_wr_en=1, rf_wr_reg=head.dest_lo, rf_wr_data=head.result[63:0].
REQ-026 In HI: rf_wr_en=1, rf_wr_reg=head.dest_hi, rf_wr_data=head.result[127:64].
REQ-027 In IDLE: rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0.
REQ-028 rf_wr_en low on rf_wr_ready SHALL hold state and outputs stable until completion (stall indefinitely).
REQ-029 LO completion with head.wr_hi=1 SHALL go to HI, no pop.
REQ-030 LO completion with wr_hi=0, or HI completion, SHALL pop head, pulse retire that cycle, then go LO if (count after pop) != 0 or push, else IDLE.
REQ-031 flags_wr_en SHALL pulse in the LO completion cycle iff head.wr_flags, flags_wr_data=head.flags; else flags_wr_data=0.
REQ-032 Push and pop in the same cycle SHALL leave count unchanged; both pointers advance.
REQ-033 Entries SHALL drain in push order; max throughput one GPR write per cycle.
REQ-034 Latency: push in cycle N to empty IDLE buffer -> rf_wr_en high in cycle N+1.
REQ-035 dest_lo == dest_hi with wr_hi=1 SHALL perform both writes in order; high word wins.

Reset
REQ-036 While reset high at an edge: count, pointers := 0; state := IDLE; all buffered entries discarded.
REQ-037 During and after reset until a push: rf_wr_en, flags_wr_en, retire, busy = 0; rf_wr_reg, rf_wr_data, flags_wr_data = 0; in_ready = 0 while reset high, 1 the cycle after.
REQ-038 Reset mid-write (LO or HI, stalled or not) SHALL abort; no further write of that entry, no retire.

Verification
REQ-039 Single push result=0x...0000_0000_0000_002A, dest_lo=3, wr_hi=0, wr_flags=1, flags=0x44, rf_wr_ready=1 -> cycle N+1: rf_wr_en, reg 3, data 0x2A, flags_wr_en with 0x44, retire; cycle N+2 IDLE, busy=0.
REQ-040 Push result={0x1111,0x2222}, dest_lo=0, dest_hi=2, wr_hi=1 -> N+1 write R0=0x2222, N+2 write R2=0x1111 with retire; flags_wr_en stays 0 if wr_flags=0.
REQ-041 rf_wr_ready=0, push 5 entries back-to-back (DEPTH=4) -> 4 accepted, in_ready low after 4th, 5th dropped; release ready -> 4 writes in order on consecutive cycles.
REQ-042 Full buffer, exe_mem high in pop cycle -> push refused; next cycle in_ready=1, push accepted, count back to 4; pointer wrap verified over 10+ entries.
REQ-043 Stall in HI for 3 cycles then reset -> outputs zero next cycle, no retire, count=0, in_ready=1 one cycle after reset falls.
